fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage of the RV32I pipeline. It is the producer side of the fetch-to-decode interface and drives the decode stage's pc/insn inputs.
- Issues word requests to instruction memory over a request/response handshake with variable latency.
- Buffers returned instructions in a 2-entry in-order queue and presents the head to decode.
- Honours the pipeline stall from the hazard unit.
- Handles control-flow redirects by discarding any instructions already buffered or still in flight.

Parameters:
DWIDTH, 32, instruction/data width
AWIDTH, 32, address width
BASE_ADDR, 32'h0100_0000, reset PC (IMEM_BASE_ADDR)
DEPTH, 2, max (in-flight + buffered) instructions

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_i  in  1  decode stalled; hold outputs, no pop
redirect_i  in  1  branch/jump taken; flush and restart
redirect_pc_i  in  AWIDTH  restart address
imem_req_o  out  1  memory request valid
imem_addr_o  out  AWIDTH  request word address
imem_ready_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid (in order, >=1 cycle after accept)
imem_rdata_i  in  DWIDTH  response instruction
valid_o  out  1  pc_o/insn_o hold a real instruction
pc_o  out  AWIDTH  PC of head instruction
insn_o  out  DWIDTH  head instruction, or NOP when not valid

Behaviour:
State
- req_pc: next address to request.
- inflight: count of accepted requests not yet responded, 0..DEPTH.
- drop_cnt: count of in-flight responses to discard, 0..DEPTH.
- Queue: DEPTH entries of {pc, insn}, plus a pending-PC FIFO (DEPTH entries) that records the address of every accepted request.

Reset (rst=1)
- req_pc=BASE_ADDR; inflight, drop_cnt, queue count=0.
- imem_req_o=0, valid_o=0, pc_o=BASE_ADDR, insn_o=32'h0000_0013 (NOP).
- Instruction memory shares rst; responses to pre-reset requests never arrive.

Output
- valid_o = (count != 0).
- pc_o/insn_o = head entry. When empty: insn_o=NOP, pc_o=last popped pc (BASE_ADDR after reset).
- All outputs are registered-state driven; stall_i and redirect_i only gate updates.

Pop
- pop = valid_o && !stall_i && !redirect_i. Decode captures the head on that clock edge.

Issue
- imem_req_o = !rst && !redirect_i && (inflight + count - pop < DEPTH).
- imem_addr_o = req_pc.
- Accept = imem_req_o && imem_ready_i. On accept: req_pc += 4 (wraps mod 2^AWIDTH), push req_pc to pending-PC FIFO, inflight += 1.
- While imem_ready_i=0, the request and address are held stable.

Response
- On imem_rvalid_i: inflight -= 1 and pop the pending-PC FIFO.
- If drop_cnt>0: discard the response, drop_cnt -= 1.
- Else: push {pending pc, imem_rdata_i} into the queue.
- Push and pop in the same cycle leave count unchanged.
- The credit rule guarantees no overflow. A response with inflight=0 is an assertion error.

Redirect (priority over stall and pop)
- Queue count <= 0; req_pc <= {redirect_pc_i[AWIDTH-1:2], 2'b00}.
- drop_cnt <= inflight - (imem_rvalid_i ? 1 : 0).
- Any response arriving in the redirect cycle is discarded.
- No request is issued in the redirect cycle; the first request to the new address goes out on the next cycle.
- valid_o=0 on the cycle after a redirect.

Performance
- Single-cycle memory, ready=1, no stall: first valid_o 2 cycles after reset release, then one instruction per cycle. PCs are sequential with no gaps or duplicates.

Test Plan:
1. Reset release, 1-cycle memory, ready=1 -> addresses 0x01000000, 0x01000004, 0x01000008 on consecutive cycles; valid_o from cycle 2; pc_o steps by 4 each cycle.
2. stall_i high 3 cycles mid-stream -> pc_o/insn_o frozen; imem_req_o drops once inflight+count=2; after release, next pc_o = frozen pc+4 with no skipped or repeated PC.
3. 3-cycle memory, 2 requests in flight, redirect_i to 0x01000100 -> both stale responses discarded; next valid_o has pc_o=0x01000100 and insn from that address; drop_cnt returns to 0.
4. imem_ready_i low 4 cycles -> imem_req_o stays 1 with imem_addr_o constant; req_pc advances only on the accept cycle.
5. redirect_i and stall_i high together with 2 entries buffered, redirect_pc_i=0x01000102 -> queue cleared; valid_o=0 next cycle; next request address 0x01000100.
6. rst asserted mid-stream with entries buffered -> next cycle valid_o=0, insn_o=0x00000013, pc_o=0x01000000; first request after release is to 0x01000000.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage feeding the decode stage
//
// Issues sequential word requests to instruction memory, buffers the returned
// instructions in a small in-order queue and presents the head to decode.
// Redirects flush the queue and discard responses that are still in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_i             decode stalled: hold head, no pop
//   redirect_i          taken branch/jump: flush and restart at redirect_pc_i
//   redirect_pc_i       restart address (forced to word alignment)
//   imem_req_o          request valid toward instruction memory
//   imem_addr_o         requested word address
//   imem_ready_i        memory accepts the request this cycle
//   imem_rvalid_i       in-order response valid
//   imem_rdata_i        response instruction word
//   valid_o             pc_o/insn_o hold a real instruction
//   pc_o                PC of head instruction (last popped PC when empty)
//   insn_o              head instruction (NOP when empty)

module fetch_unit #(
   parameter int unsigned       DWIDTH    = 32,
   parameter int unsigned       AWIDTH    = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000),
   parameter int unsigned       DEPTH     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] redirect_pc_i,
   output logic              imem_req_o,
   output logic [AWIDTH-1:0] imem_addr_o,
   input  logic              imem_ready_i,
   input  logic              imem_rvalid_i,
   input  logic [DWIDTH-1:0] imem_rdata_i,
   output logic              valid_o,
   output logic [AWIDTH-1:0] pc_o,
   output logic [DWIDTH-1:0] insn_o
);

   localparam int unsigned       PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned       CNT_W      = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(DEPTH);
   localparam logic [DWIDTH-1:0] NOP        = DWIDTH'(32'h0000_0013);

   logic [AWIDTH-1:0] req_pc_q, req_pc_d;
   logic [AWIDTH-1:0] last_pc_q, last_pc_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  q_rd_q, q_rd_d, q_wr_q, q_wr_d;
   logic [PTR_W-1:0]  pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;

   logic [AWIDTH-1:0] q_pc_q    [DEPTH];
   logic [AWIDTH-1:0] q_pc_d    [DEPTH];
   logic [DWIDTH-1:0] q_insn_q  [DEPTH];
   logic [DWIDTH-1:0] q_insn_d  [DEPTH];
   logic [AWIDTH-1:0] pend_pc_q [DEPTH];
   logic [AWIDTH-1:0] pend_pc_d [DEPTH];

   logic              pop;
   logic              accept;
   logic              keep;
   logic [CNT_W:0]    credit_used;
   logic [AWIDTH-1:0] resp_pc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign valid_o     = (count_q != '0);
   assign pc_o        = valid_o ? q_pc_q[q_rd_q] : last_pc_q;
   assign insn_o      = valid_o ? q_insn_q[q_rd_q] : NOP;
   assign imem_addr_o = req_pc_q;

   always_comb begin
      pop = valid_o && !stall_i && !redirect_i;
      // Slots already claimed by buffered plus in-flight instructions; an entry
      // popped this cycle frees its slot for a new request immediately.
      credit_used = {1'b0, inflight_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop};
      imem_req_o  = !rst && !redirect_i && (credit_used < CREDIT_MAX);
      accept      = imem_req_o && imem_ready_i;
      keep        = imem_rvalid_i && !redirect_i && (drop_cnt_q == '0);
      resp_pc     = pend_pc_q[pend_rd_q];

      req_pc_d   = req_pc_q;
      last_pc_d  = last_pc_q;
      drop_cnt_d = drop_cnt_q;
      q_rd_d     = q_rd_q;
      q_wr_d     = q_wr_q;
      pend_rd_d  = pend_rd_q;
      pend_wr_d  = pend_wr_q;
      q_pc_d     = q_pc_q;
      q_insn_d   = q_insn_q;
      pend_pc_d  = pend_pc_q;

      if (accept) begin
         req_pc_d             = req_pc_q + AWIDTH'(4);
         pend_pc_d[pend_wr_q] = req_pc_q;
         pend_wr_d            = ptr_inc(pend_wr_q);
      end

      // Every response retires one pending PC, whether it is kept or dropped.
      if (imem_rvalid_i) begin
         pend_rd_d = ptr_inc(pend_rd_q);
      end

      if (imem_rvalid_i && !redirect_i && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end

      if (keep) begin
         q_pc_d[q_wr_q]   = resp_pc;
         q_insn_d[q_wr_q] = imem_rdata_i;
         q_wr_d           = ptr_inc(q_wr_q);
      end

      if (pop) begin
         last_pc_d = q_pc_q[q_rd_q];
         q_rd_d    = ptr_inc(q_rd_q);
      end

      inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(imem_rvalid_i);
      count_d    = count_q + CNT_W'(keep) - CNT_W'(pop);

      // Redirect wins over everything: whatever is still outstanding after
      // this cycle belongs to the old path and must be thrown away on return.
      if (redirect_i) begin
         count_d    = '0;
         q_rd_d     = '0;
         q_wr_d     = '0;
         req_pc_d   = redirect_pc_i & ~AWIDTH'(3);
         drop_cnt_d = inflight_q - CNT_W'(imem_rvalid_i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_pc_q   <= BASE_ADDR;
         last_pc_q  <= BASE_ADDR;
         inflight_q <= '0;
         drop_cnt_q <= '0;
         count_q    <= '0;
         q_rd_q     <= '0;
         q_wr_q     <= '0;
         pend_rd_q  <= '0;
         pend_wr_q  <= '0;
      end else begin
         req_pc_q   <= req_pc_d;
         last_pc_q  <= last_pc_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         count_q    <= count_d;
         q_rd_q     <= q_rd_d;
         q_wr_q     <= q_wr_d;
         pend_rd_q  <= pend_rd_d;
         pend_wr_q  <= pend_wr_d;
      end
   end

   // Storage only; validity is tracked by the counters and pointers above.
   always_ff @(posedge clk) begin
      q_pc_q    <= q_pc_d;
      q_insn_q  <= q_insn_d;
      pend_pc_q <= pend_pc_d;
   end

   always_ff @(posedge clk) begin
      if (!rst && imem_rvalid_i) begin
         assert (inflight_q != '0);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i = 1'b1;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] insn_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
   } exp_t;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mreq_t;

   exp_t  exp_q[$];
   mreq_t mq[$];
   int    n_checks = 0;
   int    n_pass = 0;
   int    mem_lat = 1;
   int    cyc = 0;
   int    last_due = 0;

   always #5 clk = ~clk;

   fetch_unit #(
      .DWIDTH(32),
      .AWIDTH(32),
      .BASE_ADDR(32'h0100_0000),
      .DEPTH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall_i(stall_i),
      .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .imem_req_o(imem_req_o),
      .imem_addr_o(imem_addr_o),
      .imem_ready_i(imem_ready_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i(imem_rdata_i),
      .valid_o(valid_o),
      .pc_o(pc_o),
      .insn_o(insn_o)
   );

   // Memory image: addi x1,x0,<word index> so every word is distinct.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[13:2], 20'h00093};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] insn);
      exp_t e;
      e.pc   = pc;
      e.insn = insn;
      exp_q.push_back(e);
   endtask

   // Instruction memory: in-order, latency mem_lat cycles, shares rst.
   always @(negedge clk) begin
      mreq_t r;
      cyc++;
      #1;
      if (rst) begin
         mq.delete();
         last_due = 0;
         imem_rvalid_i = 1'b0;
      end else if (mq.size() != 0 && mq[0].due <= cyc) begin
         r = mq.pop_front();
         imem_rvalid_i = 1'b1;
         imem_rdata_i = mem_word(r.addr);
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i = '0;
      end
      #1;
      if (!rst && imem_req_o && imem_ready_i) begin
         r.due  = (cyc + mem_lat > last_due) ? cyc + mem_lat : last_due + 1;
         r.addr = imem_addr_o;
         mq.push_back(r);
         last_due = r.due;
      end
   end

   // Monitor: every decode capture is compared against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!rst && valid_o && !stall_i && !redirect_i) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected_pop: got pc 0x%08h, expected no instruction", pc_o);
         end else begin
            e = exp_q.pop_front();
            check("sb_pc", pc_o, e.pc);
            check("sb_insn", insn_o, e.insn);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      bit found;

      repeat (3) @(negedge clk);
      #3;
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_pc", pc_o, 32'h0100_0000);
      check("rst_insn", insn_o, 32'h0000_0013);
      check("rst_req", 32'(imem_req_o), 32'd0);

      // Sequential fetch, then a 3-cycle stall mid-stream.
      push_exp(32'h0100_0000, 32'h0000_0093);
      push_exp(32'h0100_0004, 32'h0010_0093);
      push_exp(32'h0100_0008, 32'h0020_0093);
      push_exp(32'h0100_000C, 32'h0030_0093);
      push_exp(32'h0100_0010, 32'h0040_0093);
      push_exp(32'h0100_0014, 32'h0050_0093);
      push_exp(32'h0100_0018, 32'h0060_0093);
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         rst = 1'b0;
         stall_i = (c >= 6 && c <= 8) || (c >= 12);
         #3;
         if (c <= 2) begin
            check("t1_req", 32'(imem_req_o), 32'd1);
            check("t1_addr", imem_addr_o, 32'(32'h0100_0000 + 4 * c));
            check("t1_valid", 32'(valid_o), 32'(c == 2));
         end
         if (c >= 6 && c <= 8) begin
            check("t2_pc_frozen", pc_o, 32'h0100_0010);
            check("t2_insn_frozen", insn_o, 32'h0040_0093);
            check("t2_req_drop", 32'(imem_req_o), 32'd0);
         end
      end
      check("t2_drain", 32'(exp_q.size()), 32'd0);

      // 3-cycle memory: two requests in flight, then redirect.
      @(negedge clk);
      mem_lat = 3;
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0100_0040;
      @(negedge clk);
      redirect_i = 1'b0;
      #3;
      check("t3_req0", 32'(imem_req_o), 32'd1);
      check("t3_addr0", imem_addr_o, 32'h0100_0040);
      @(negedge clk);
      #3;
      check("t3_addr1", imem_addr_o, 32'h0100_0044);
      @(negedge clk);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0100_0100;
      #3;
      check("t3_inflight", 32'(dut.inflight_q), 32'd2);
      check("t3_req_redirect", 32'(imem_req_o), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         redirect_i = 1'b0;
         #3;
         if (valid_o) found = 1'b1;
      end
      check("t3_valid_seen", 32'(found), 32'd1);
      check("t3_pc", pc_o, 32'h0100_0100);
      check("t3_insn", insn_o, 32'h0400_0093);
      check("t3_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
      repeat (2) @(negedge clk);

      // Memory not ready for 4 cycles while the stream resumes.
      push_exp(32'h0100_0100, 32'h0400_0093);
      push_exp(32'h0100_0104, 32'h0410_0093);
      push_exp(32'h0100_0108, 32'h0420_0093);
      push_exp(32'h0100_010C, 32'h0430_0093);
      push_exp(32'h0100_0110, 32'h0440_0093);
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         mem_lat = 1;
         stall_i = (k >= 9);
         imem_ready_i = (k >= 4);
         #3;
         if (k <= 4) begin
            check("t4_req_held", 32'(imem_req_o), 32'd1);
            check("t4_addr_held", imem_addr_o, 32'h0100_0108);
         end
         if (k == 5) check("t4_addr_adv", imem_addr_o, 32'h0100_010C);
      end
      check("t4_drain", 32'(exp_q.size()), 32'd0);

      // Redirect and stall together with the queue full; misaligned target.
      @(negedge clk);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0100_0102;
      #3;
      check("t5_req_redirect", 32'(imem_req_o), 32'd0);
      @(negedge clk);
      redirect_i = 1'b0;
      #3;
      check("t5_valid", 32'(valid_o), 32'd0);
      check("t5_req", 32'(imem_req_o), 32'd1);
      check("t5_addr", imem_addr_o, 32'h0100_0100);
      repeat (3) @(negedge clk);

      // Reset mid-stream with the queue full.
      @(negedge clk);
      rst = 1'b1;
      push_exp(32'h0100_0000, 32'h0000_0093);
      push_exp(32'h0100_0004, 32'h0010_0093);
      push_exp(32'h0100_0008, 32'h0020_0093);
      @(negedge clk);
      rst = 1'b0;
      stall_i = 1'b0;
      #3;
      check("t6_valid", 32'(valid_o), 32'd0);
      check("t6_insn", insn_o, 32'h0000_0013);
      check("t6_pc", pc_o, 32'h0100_0000);
      check("t6_req", 32'(imem_req_o), 32'd1);
      check("t6_addr", imem_addr_o, 32'h0100_0000);
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
         stall_i = (k >= 6);
      end
      #3;
      check("t6_drain", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
